// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared widths, holding-FSM encoding and timing defaults for input_logic
package input_pkg;

  localparam int ENTRY_W   = 16;
  localparam int NIBBLE_W  = 4;
  localparam int MAX_COUNT = 4;
  localparam int COUNT_W   = 3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int DEFAULT_REPEAT_RATE     = 10000000;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  // Append a nibble on the right; the oldest nibble falls off the left.
  function automatic logic [ENTRY_W-1:0] shift_in(input logic [ENTRY_W-1:0]  word,
                                                  input logic [NIBBLE_W-1:0] nib);
    return {word[ENTRY_W-NIBBLE_W-1:0], nib};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-FF synchronizer, stability counter and press pulse for one button
module button_debounce
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/input_logic.sv
// rtl/input_logic.sv - switch/button hex entry with CPU handshake; INPUT_AUTOREPEAT_EN adds SHIFT auto-repeat
module input_logic
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
  input  logic                MCLK,
  input  logic                RESET,
  input  logic [NIBBLE_W-1:0] SW,
  input  logic                BTN_SHIFT,
  input  logic                BTN_COMMIT,
  input  logic                BTN_CLEAR,
  output logic [ENTRY_W-1:0]  input_port,
  output logic                input_valid,
  input  logic                input_ack,
  output logic [ENTRY_W-1:0]  entry,
  output logic [COUNT_W-1:0]  entry_count,
  output logic                overrun
);

  logic [NIBBLE_W-1:0] sw_meta;
  logic [NIBBLE_W-1:0] sw_sync;
  logic                shift_level;
  logic                shift_press;
  logic                commit_level;
  logic                commit_press;
  logic                clear_level;
  logic                clear_press;
  logic                shift_pulse;
  logic                commit_go;
  logic                shift_go;
  logic                commit_accept;
  logic                commit_lost;
  logic                unused_levels;
  hold_state_t         state;

  // Bring the raw switches into the MCLK domain.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_shift (
    .MCLK(MCLK), .RESET(RESET), .btn(BTN_SHIFT), .level(shift_level), .press(shift_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
    .MCLK(MCLK), .RESET(RESET), .btn(BTN_COMMIT), .level(commit_level), .press(commit_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .MCLK(MCLK), .RESET(RESET), .btn(BTN_CLEAR), .level(clear_level), .press(clear_press)
  );

`ifdef INPUT_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic             rep_pulse;

  // Repeat timer: first extra pulse REPEAT_DELAY after the press, then every REPEAT_RATE while held.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      rep_pulse <= 1'b0;
    end else begin
      rep_pulse <= 1'b0;
      if (shift_press) begin
        rep_cnt   <= REP_W'(1);
        rep_first <= 1'b1;
      end else if (shift_level) begin
        if (rep_cnt == (rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_RATE - 1))) begin
          rep_pulse <= 1'b1;
          rep_cnt   <= REP_W'(1);
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end
    end
  end

  assign shift_pulse   = shift_press | rep_pulse;
  assign unused_levels = commit_level ^ clear_level;
`else
  assign shift_pulse   = shift_press;
  assign unused_levels = shift_level ^ commit_level ^ clear_level ^ (REPEAT_DELAY == REPEAT_RATE);
`endif

  // Resolve coincident pulses: CLEAR beats COMMIT beats SHIFT.
  always_comb begin
    commit_go     = commit_press & ~clear_press;
    shift_go      = shift_pulse & ~clear_press & ~commit_press;
    commit_accept = commit_go && (entry_count != '0) && ((state == EMPTY) || input_ack);
    commit_lost   = commit_go && (entry_count != '0) && (state == FULL) && !input_ack;
  end

  assign input_valid = (state == FULL);

  // Entry datapath and the EMPTY/FULL holding FSM.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state       <= EMPTY;
      input_port  <= '0;
      entry       <= '0;
      entry_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (clear_press) begin
        entry       <= '0;
        entry_count <= '0;
        overrun     <= 1'b0;
      end else if (commit_accept) begin
        input_port  <= entry;
        entry       <= '0;
        entry_count <= '0;
      end else if (commit_lost) begin
        overrun <= 1'b1;
      end else if (shift_go) begin
        entry <= shift_in(entry, sw_sync);
        if (entry_count != COUNT_W'(MAX_COUNT)) begin
          entry_count <= entry_count + 1'b1;
        end
      end

      case (state)
        EMPTY:   if (commit_accept) state <= FULL;
        FULL:    if (input_ack && !commit_accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_input_logic.sv
// tb/tb_input_logic.sv - self-checking bench for input_logic
module tb_input_logic;

  localparam int DB = 4;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  SW = 4'h0;
  logic        BTN_SHIFT = 1'b0;
  logic        BTN_COMMIT = 1'b0;
  logic        BTN_CLEAR = 1'b0;
  logic        input_ack = 1'b0;
  logic [15:0] input_port;
  logic        input_valid;
  logic [15:0] entry;
  logic [2:0]  entry_count;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  input_logic #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(20), .REPEAT_RATE(8)) dut (
    .MCLK(MCLK), .RESET(RESET), .SW(SW), .BTN_SHIFT(BTN_SHIFT), .BTN_COMMIT(BTN_COMMIT),
    .BTN_CLEAR(BTN_CLEAR), .input_port(input_port), .input_valid(input_valid),
    .input_ack(input_ack), .entry(entry), .entry_count(entry_count), .overrun(overrun)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    bit          clr;
    bit          cmt;
    bit          shf;
    logic [3:0]  sw;
    bit          ack;
    logic [15:0] e_entry;
    int          e_count;
    logic [15:0] e_port;
    bit          e_valid;
    bit          e_ovr;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: the staged entry is a list of at most four nibbles.
  logic [3:0]  m_q[$];
  logic [15:0] m_port;
  bit          m_valid;
  bit          m_ovr;

  function automatic vec_t mk(bit c, bit m, bit s, logic [3:0] sw, bit a,
                              logic [15:0] e, int n, logic [15:0] p, bit v, bit o);
    vec_t r;
    r.clr = c; r.cmt = m; r.shf = s; r.sw = sw; r.ack = a;
    r.e_entry = e; r.e_count = n; r.e_port = p; r.e_valid = v; r.e_ovr = o;
    return r;
  endfunction

  function automatic logic [15:0] m_entry();
    int e = 0;
    foreach (m_q[i]) e = e * 16 + int'(m_q[i]);
    return e[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] e, input int n,
                               input logic [15:0] p, input bit v, input bit o);
    check({tag, " entry"}, entry, e);
    check({tag, " entry_count"}, {13'b0, entry_count}, 16'(n));
    check({tag, " input_port"}, input_port, p);
    check({tag, " input_valid"}, {15'b0, input_valid}, {15'b0, v});
    check({tag, " overrun"}, {15'b0, overrun}, {15'b0, o});
  endtask

  task automatic model_reset();
    m_q.delete();
    m_port = '0;
    m_valid = 0;
    m_ovr = 0;
  endtask

  task automatic model_apply(input bit clr, input bit cmt, input bit shf,
                             input logic [3:0] sw, input bit ack);
    bit took = 0;
    if (clr) begin
      m_q.delete();
      m_ovr = 0;
    end else if (cmt) begin
      if (m_q.size() != 0) begin
        if (!m_valid || ack) begin
          m_port = m_entry();
          m_valid = 1;
          m_q.delete();
          took = 1;
        end else begin
          m_ovr = 1;
        end
      end
    end else if (shf) begin
      m_q.push_back(sw);
      if (m_q.size() > 4) void'(m_q.pop_front());
    end
    if (ack && !took) m_valid = 0;
  endtask

  // Clean press of the selected buttons; ack (if any) coincides with the resulting pulse.
  task automatic do_op(input bit clr, input bit cmt, input bit shf,
                       input logic [3:0] sw, input bit ack);
    SW = sw;
    if (clr || cmt || shf) begin
      BTN_CLEAR = clr;
      BTN_COMMIT = cmt;
      BTN_SHIFT = shf;
      repeat (DB + 2) @(posedge MCLK);
      @(negedge MCLK);
      input_ack = ack;
      @(posedge MCLK);
      @(negedge MCLK);
      input_ack = 1'b0;
      BTN_CLEAR = 1'b0;
      BTN_COMMIT = 1'b0;
      BTN_SHIFT = 1'b0;
    end else begin
      input_ack = ack;
      @(posedge MCLK);
      @(negedge MCLK);
      input_ack = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (DB + 4) @(negedge MCLK);
  endtask

  task automatic do_reset();
    @(negedge MCLK);
    RESET = 1'b1;
    repeat (2) @(negedge MCLK);
    RESET = 1'b0;
  endtask

  initial begin
    // Directed table, applied from reset in order.
    tbl.push_back(mk(0, 0, 1, 4'hA, 0, 16'h000A, 1, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'hB, 0, 16'h00AB, 2, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'hC, 0, 16'h0ABC, 3, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'hD, 0, 16'hABCD, 4, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 16'h0000, 0, 16'hABCD, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 16'h0000, 0, 16'hABCD, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h1, 0, 16'h0001, 1, 16'hABCD, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h2, 0, 16'h0012, 2, 16'hABCD, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h3, 0, 16'h0123, 3, 16'hABCD, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h4, 0, 16'h1234, 4, 16'hABCD, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h5, 0, 16'h2345, 4, 16'hABCD, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 16'h0000, 0, 16'hABCD, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h1, 0, 16'h0001, 1, 16'hABCD, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h2, 0, 16'h0012, 2, 16'hABCD, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 16'h0000, 0, 16'h0012, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'h3, 0, 16'h0003, 1, 16'h0012, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'h4, 0, 16'h0034, 2, 16'h0012, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 16'h0034, 2, 16'h0012, 1, 1));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 16'h0000, 0, 16'h0012, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'h5, 0, 16'h0005, 1, 16'h0012, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'h6, 0, 16'h0056, 2, 16'h0012, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 1, 16'h0000, 0, 16'h0056, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'h7, 0, 16'h0007, 1, 16'h0056, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'h9, 0, 16'h0000, 0, 16'h0056, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 16'h0000, 0, 16'h0056, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 16'h0000, 0, 16'h0056, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 16'h0000, 0, 16'h0056, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h8, 0, 16'h0008, 1, 16'h0056, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'hF, 0, 16'h0000, 0, 16'h0008, 1, 0));

    // Reset state, sampled while RESET is held.
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    check_outputs("reset", 16'h0000, 0, 16'h0000, 0, 0);
    RESET = 1'b0;
    @(negedge MCLK);

    foreach (tbl[i]) begin
      do_op(tbl[i].clr, tbl[i].cmt, tbl[i].shf, tbl[i].sw, tbl[i].ack);
      check_outputs($sformatf("vec%0d", i), tbl[i].e_entry, tbl[i].e_count,
                    tbl[i].e_port, tbl[i].e_valid, tbl[i].e_ovr);
      settle();
    end

    // Bounce rejection: 1,0,1,0 on consecutive cycles, then a steady 1.
    do_reset();
    @(negedge MCLK);
    SW = 4'h7;
    BTN_SHIFT = 1'b1; @(negedge MCLK);
    BTN_SHIFT = 1'b0; @(negedge MCLK);
    BTN_SHIFT = 1'b1; @(negedge MCLK);
    BTN_SHIFT = 1'b0; @(negedge MCLK);
    BTN_SHIFT = 1'b1;
    repeat (DB + 2) @(posedge MCLK);
    @(negedge MCLK);
    check("bounce before action count", {13'b0, entry_count}, 16'd0);
    @(posedge MCLK);
    @(negedge MCLK);
    check("bounce action count", {13'b0, entry_count}, 16'd1);
    check("bounce action entry", entry, 16'h0007);
    repeat (12) @(negedge MCLK);
    check("bounce held single count", {13'b0, entry_count}, 16'd1);
    BTN_SHIFT = 1'b0;
    settle();

    // Reset mid-debounce with the button released before the window completes.
    do_op(0, 1, 0, 4'h0, 0);
    settle();
    check("pre-reset valid", {15'b0, input_valid}, 16'd1);
    SW = 4'h5;
    BTN_SHIFT = 1'b1;
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    RESET = 1'b1;
    @(negedge MCLK);
    BTN_SHIFT = 1'b0;
    @(negedge MCLK);
    RESET = 1'b0;
    check_outputs("mid-reset", 16'h0000, 0, 16'h0000, 0, 0);
    repeat (12) @(negedge MCLK);
    check("no pulse after reset count", {13'b0, entry_count}, 16'd0);
    check("no pulse after reset entry", entry, 16'h0000);

    // Button held across reset: exactly one press after a fresh window.
    SW = 4'h9;
    BTN_SHIFT = 1'b1;
    repeat (4) @(posedge MCLK);
    @(negedge MCLK);
    RESET = 1'b1;
    @(negedge MCLK);
    RESET = 1'b0;
    repeat (DB + 3) @(posedge MCLK);
    @(negedge MCLK);
    check("held across reset count", {13'b0, entry_count}, 16'd1);
    check("held across reset entry", entry, 16'h0009);
    repeat (10) @(negedge MCLK);
    check("held across reset single", {13'b0, entry_count}, 16'd1);
    BTN_SHIFT = 1'b0;
    settle();

    // Randomized operations against the behavioural model.
    do_reset();
    model_reset();
    @(negedge MCLK);
    for (int k = 0; k < 50; k++) begin
      int r;
      bit c, m, s, a;
      logic [3:0] sw;
      r = $urandom_range(0, 9);
      sw = 4'($urandom_range(0, 15));
      c = 0; m = 0; s = 0; a = 0;
      if (r <= 4) s = 1;
      else if (r <= 6) begin m = 1; a = ($urandom_range(0, 3) == 0); end
      else if (r == 7) c = 1;
      else if (r == 8) a = 1;
      else begin
        int mask = $urandom_range(1, 7);
        c = mask[0]; m = mask[1]; s = mask[2];
        a = ($urandom_range(0, 1) == 1);
      end
      do_op(c, m, s, sw, a);
      model_apply(c, m, s, sw, a);
      check_outputs($sformatf("rnd%0d", k), m_entry(), m_q.size(), m_port, m_valid, m_ovr);
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
